// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared load encodings, default buffer depth and load extension helper
package rv_pkg;

  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110,
    LD_DX = 3'b111
  } load_f3_e;

  // Extend right-aligned raw load data to 64 bits according to the load type.
  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] d);
    logic [63:0] r;
    case (f3)
      LD_B:    r = {{56{d[7]}}, d[7:0]};
      LD_H:    r = {{48{d[15]}}, d[15:0]};
      LD_W:    r = {{32{d[31]}}, d[31:0]};
      LD_BU:   r = {56'd0, d[7:0]};
      LD_HU:   r = {48'd0, d[15:0]};
      LD_WU:   r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// rtl/rv_wb_fifo.sv - in-order buffer of pending load results with per-entry kill
module rv_wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [63:0] push_data,
  input  logic        pop,
  input  logic        kill_en,
  input  logic [4:0]  kill_rd,
  output logic        full,
  output logic        empty,
  output logic [4:0]  head_rd,
  output logic [63:0] head_data,
  output logic        head_kill,
  output logic [31:0] pend
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    rd_q    [DEPTH];
  logic [63:0]   data_q  [DEPTH];
  logic          kill_q  [DEPTH];
  logic          valid_q [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_rd   = rd_q[rptr];
  assign head_data = data_q[rptr];
  assign head_kill = kill_q[rptr];

  // Entry storage, pointers and occupancy; kills land before a same-cycle push so a new entry starts live.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
        kill_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (rd_q[i] == kill_rd)) kill_q[i] <= 1'b1;
        end
      end
      if (do_push) begin
        rd_q[wptr]    <= push_rd;
        data_q[wptr]  <= push_data;
        kill_q[wptr]  <= 1'b0;
        valid_q[wptr] <= 1'b1;
        wptr          <= ptr_inc(wptr);
      end
      if (do_pop) begin
        valid_q[rptr] <= 1'b0;
        rptr          <= ptr_inc(rptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending-register mask from live entries; x0 is never reported.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i]) pend[rd_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

endmodule

// File: rtl/rv_wb_arb.sv
// rtl/rv_wb_arb.sv - register-file write-back arbiter between ALU results and buffered loads
module rv_wb_arb
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        alu_vld_i,
  output logic        alu_rdy_o,
  input  logic [4:0]  alu_rd_i,
  input  logic [63:0] alu_data_i,
  input  logic        lsu_vld_i,
  output logic        lsu_rdy_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [63:0] lsu_data_i,
  output logic        wr_en_o,
  output logic [4:0]  wr_reg_o,
  output logic [63:0] wr_data_o,
  output logic [31:0] pend_o
);

  logic        full;
  logic        empty;
  logic [4:0]  head_rd;
  logic [63:0] head_data;
  logic        head_kill;
  logic        alu_xfer;
  logic        lsu_xfer;
  logic        fifo_pop;
  logic        kill_en;
  logic        sel_en;
  logic [4:0]  sel_rd;
  logic [63:0] sel_data;

  // Space is judged on the registered count only, so a full buffer drains its head before the ALU is let back in.
  assign lsu_rdy_o = ~full;
  assign alu_rdy_o = ~full;
  assign alu_xfer  = alu_vld_i & alu_rdy_o;
  assign lsu_xfer  = lsu_vld_i & lsu_rdy_o;
  assign fifo_pop  = ~alu_xfer & ~empty;
  assign kill_en   = alu_xfer & (alu_rd_i != 5'd0);

  rv_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (lsu_xfer),
    .push_rd   (lsu_rd_i),
    .push_data (load_extend(lsu_funct3_i, lsu_data_i)),
    .pop       (fifo_pop),
    .kill_en   (kill_en),
    .kill_rd   (alu_rd_i),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .head_kill (head_kill),
    .pend      (pend_o)
  );

  // Choose this cycle's write: ALU first, else the buffer head; x0 and killed entries are consumed silently.
  always_comb begin
    sel_en   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_xfer) begin
      sel_en   = (alu_rd_i != 5'd0);
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
    end else if (fifo_pop) begin
      sel_en   = ~head_kill & (head_rd != 5'd0);
      sel_rd   = head_rd;
      sel_data = head_data;
    end
  end

  // Register the selected write so it reaches the register file one cycle after selection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_en_o   <= 1'b0;
      wr_reg_o  <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o   <= sel_en;
      wr_reg_o  <= sel_rd;
      wr_data_o <= sel_data;
    end
  end

endmodule
